stream_if_fifo: RTL and testbench
=================================

Name: stream_if_fifo

Overview:
Parametrised successor to the plain valid/data interface pass-through. It sits between a sink modport and a source modport of a new `stream_if` interface, which carries `valid`, `ready` and `data[DW-1:0]`. It adds `ready` backpressure, DEPTH-entry buffering, an occupancy count and an almost-full flag. It is used wherever interface-connected blocks need elastic decoupling instead of a wire-through.

Parameters:
DW, 8, payload width in bits (>=1)
DEPTH, 4, number of buffer entries; a power of two and >=2
AF_LEVEL, DEPTH-1, almost_full asserts when level >= AF_LEVEL; legal range 1..DEPTH

Ports:
clk  input  1  sole clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
in_if  stream_if.sink_mp  DW+2  upstream: valid, data in; ready out
out_if  stream_if.source_mp  DW+2  downstream: valid, data out; ready in
level  output  $clog2(DEPTH+1)  current number of stored entries
almost_full  output  1  level >= AF_LEVEL

Behaviour:
- Reset (asynchronous assert, deassert synchronous to clk):
  - wr_ptr = rd_ptr = 0, level = 0.
  - out_if.valid = 0, almost_full = 0.
  - in_if.ready = 0 while rst is high; it is 1 in the first cycle after release.
  - Storage contents are don't-care.
- Push: in_if.valid && in_if.ready at a rising edge. Data is written at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap).
- Pop: out_if.valid && out_if.ready at a rising edge. rd_ptr increments modulo DEPTH.
- in_if.ready = !rst && (level != DEPTH).
  - It is derived from registered state only.
  - There is no combinational path from out_if.ready to in_if.ready.
- out_if.valid = (level != 0). out_if.data = entry at rd_ptr (first-word fall-through).
  - There is no combinational path from in_if to out_if.
- Latency: a word pushed at edge k is visible on out_if from the cycle after edge k. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle sustained when 0 < level < DEPTH.
- Simultaneous push and pop:
  - Not full and not empty: level unchanged, both pointers advance.
  - Empty: only the push happens (out_if.valid is 0); level goes to 1.
  - Full: only the pop happens (in_if.ready is 0); level goes to DEPTH-1.
- Level update: level_next = level + push - pop. It never exceeds DEPTH and never underflows.
- almost_full is registered and consistent with level in the same cycle.
- Source protocol: while out_if.valid && !out_if.ready, out_if.data is held stable.
- Sink protocol: upstream must hold in_if.data stable while in_if.valid && !in_if.ready. A withdrawn valid is tolerated; the word is simply not written.
- Reset mid-operation: all stored words are discarded and out_if.valid drops asynchronously. No partial word emerges after reset.
- Elaboration-time assertions: DEPTH is a power of two and >=2; AF_LEVEL is within 1..DEPTH.

Decomposition:
- Package `stream_pkg`:
  - level width function `lvl_w(depth)`, returning $clog2(depth+1).
  - pointer width localparam rule, $clog2(DEPTH).
- Interface `stream_if #(DW)`:
  - signals valid, ready, data.
  - modports `sink_mp` (input valid, data; output ready) and `source_mp` (output valid, data; input ready).
  - It lives in its own file beside the package.
- One sub-module, `stream_fifo_mem`: DEPTH x DW storage with a registered write port and an asynchronous read port.
- Pointer, level and flag logic stay in stream_if_fifo.

Test Plan:
1. Reset then idle:
   - Hold rst high 3 cycles -> level=0, out_if.valid=0, in_if.ready=0.
   - After release -> in_if.ready=1 on the first cycle.
2. Fill with out_if.ready=0, DEPTH=4, AF_LEVEL=3:
   - Push 0x11, 0x22, 0x33, 0x44 -> level goes 1, 2, 3, 4.
   - almost_full rises with level=3; in_if.ready=0 at level=4.
   - A fifth valid word is not accepted.
3. Drain:
   - Set out_if.ready=1 -> data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then out_if.valid=0 and level=0.
   - out_if.data is stable during each stall.
4. Streaming across wrap:
   - in_if.valid=1 and out_if.ready=1 for 10 cycles with data 0..9 -> output 0..9 in order, 1-cycle latency, level constant at 1.
   - Pointers wrap at least twice with no loss.
5. Simultaneous push and pop at the boundaries:
   - At level=4 with push attempted and pop -> level=3, and the pushed word is not stored.
   - At level=0 with push and pop asserted -> level=1, and nothing is emitted that cycle.
6. Reset mid-stream:
   - Assert rst asynchronously while level=2 -> out_if.valid=0 immediately, level=0.
   - After release, push 0xA5 -> the first output is 0xA5.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg: shared width helpers and defaults for the stream_if FIFO slice.
package stream_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 4;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/stream_if.sv
// stream_if: valid/ready/data handshake bundle with sink and source views.
interface stream_if #(
    parameter int DW = 8
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport sink_mp   (input valid, data, output ready);
    modport source_mp (output valid, data, input ready);
endinterface

// File: rtl/stream_fifo_mem.sv
// stream_fifo_mem: DEPTH x DW storage, registered write port, asynchronous read port.
module stream_fifo_mem
    import stream_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [DW-1:0]             wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [DW-1:0]             rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Contents carry no reset; a stored word is only visible once level covers it.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_if_fifo.sv
// stream_if_fifo: elastic DEPTH-entry FIFO between two stream_if ports,
// first-word fall-through output with occupancy level and almost_full flag.
module stream_if_fifo
    import stream_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    stream_if.sink_mp                 in_if,
    stream_if.source_mp               out_if,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      almost_full
);

    localparam int LW = lvl_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("stream_if_fifo: DEPTH must be a power of two and >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("stream_if_fifo: AF_LEVEL must lie within 1..DEPTH");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          almost_full_q, almost_full_d;
    logic          push, pop;

    // Ready depends only on registered level, so out_if.ready never reaches it.
    assign in_if.ready  = !rst && (level_q != LW'(DEPTH));
    assign out_if.valid = (level_q != '0);

    always_comb begin
        push          = in_if.valid && in_if.ready;
        pop           = out_if.valid && out_if.ready;
        wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d       = level_q + LW'(push) - LW'(pop);
        almost_full_d = (level_d >= LW'(AF_LEVEL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            almost_full_q <= almost_full_d;
        end
    end

    stream_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_if.data),
        .raddr (rd_ptr_q),
        .rdata (out_if.data)
    );

    assign level       = level_q;
    assign almost_full = almost_full_q;

endmodule

// File: tb/tb_stream_if_fifo.sv
// tb_stream_if_fifo: directed checks of stream_if_fifo with DEPTH=4, AF_LEVEL=3.
module tb_stream_if_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] level;
    logic       almost_full;
    int         checks = 0;
    int         errors = 0;

    stream_if #(.DW(8)) in_s ();
    stream_if #(.DW(8)) out_s ();

    stream_if_fifo #(
        .DW       (8),
        .DEPTH    (4),
        .AF_LEVEL (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_if       (in_s),
        .out_if      (out_s),
        .level       (level),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        in_s.valid  = 1'b0;
        in_s.data   = 8'h00;
        out_s.ready = 1'b0;

        // 1: reset held for three cycles, then release
        repeat (3) @(negedge clk);
        check("rst_level", 32'(level), 0);
        check("rst_ovalid", 32'(out_s.valid), 0);
        check("rst_iready", 32'(in_s.ready), 0);
        check("rst_af", 32'(almost_full), 0);
        rst = 1'b0;
        #1;
        check("rel_iready", 32'(in_s.ready), 1);
        @(negedge clk);

        // 2: fill with downstream stalled
        in_s.valid = 1'b1;
        in_s.data  = 8'h11;
        step();
        check("fill1_level", 32'(level), 1);
        check("fill1_ovalid", 32'(out_s.valid), 1);
        check("fill1_odata", 32'(out_s.data), 32'h11);
        check("fill1_af", 32'(almost_full), 0);
        in_s.data = 8'h22;
        step();
        check("fill2_level", 32'(level), 2);
        check("fill2_af", 32'(almost_full), 0);
        in_s.data = 8'h33;
        step();
        check("fill3_level", 32'(level), 3);
        check("fill3_af", 32'(almost_full), 1);
        in_s.data = 8'h44;
        step();
        check("fill4_level", 32'(level), 4);
        check("fill4_iready", 32'(in_s.ready), 0);
        check("fill4_af", 32'(almost_full), 1);
        in_s.data = 8'h55;
        step();
        check("fifth_level", 32'(level), 4);
        check("stall_odata", 32'(out_s.data), 32'h11);

        // 3: drain
        in_s.valid  = 1'b0;
        out_s.ready = 1'b1;
        #1;
        check("drain0_odata", 32'(out_s.data), 32'h11);
        step();
        check("drain1_odata", 32'(out_s.data), 32'h22);
        check("drain1_level", 32'(level), 3);
        step();
        check("drain2_odata", 32'(out_s.data), 32'h33);
        check("drain2_af", 32'(almost_full), 0);
        step();
        check("drain3_odata", 32'(out_s.data), 32'h44);
        check("drain3_level", 32'(level), 1);
        step();
        check("drain4_ovalid", 32'(out_s.valid), 0);
        check("drain4_level", 32'(level), 0);

        // 4: streaming across pointer wrap
        in_s.valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_s.data = 8'(i);
            step();
            check($sformatf("stream%0d_odata", i), 32'(out_s.data), 32'(i));
            check($sformatf("stream%0d_level", i), 32'(level), 1);
        end
        in_s.valid = 1'b0;
        step();
        check("stream_end_level", 32'(level), 0);

        // 5a: push attempted while full together with a pop
        out_s.ready = 1'b0;
        in_s.valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_s.data = 8'hA0 + 8'(i);
            step();
        end
        check("full_level", 32'(level), 4);
        in_s.data   = 8'hBB;
        out_s.ready = 1'b1;
        step();
        check("fullpp_level", 32'(level), 3);
        check("fullpp_odata", 32'(out_s.data), 32'hA1);
        in_s.valid = 1'b0;
        step();
        check("fullpp_d2", 32'(out_s.data), 32'hA2);
        step();
        check("fullpp_d3", 32'(out_s.data), 32'hA3);
        step();
        check("fullpp_gone", 32'(level), 0);

        // 5b: push and pop asserted while empty
        in_s.valid = 1'b1;
        in_s.data  = 8'hC7;
        #1;
        check("emptypp_ovalid", 32'(out_s.valid), 0);
        step();
        check("emptypp_level", 32'(level), 1);
        check("emptypp_odata", 32'(out_s.data), 32'hC7);
        in_s.valid  = 1'b0;
        out_s.ready = 1'b0;
        step();
        check("emptypp_stall", 32'(level), 1);
        out_s.ready = 1'b1;
        step();
        check("emptypp_drain", 32'(level), 0);

        // 6: asynchronous reset mid-stream
        out_s.ready = 1'b0;
        in_s.valid  = 1'b1;
        in_s.data   = 8'hD1;
        step();
        in_s.data = 8'hD2;
        step();
        check("pre_rst_level", 32'(level), 2);
        #2 rst = 1'b1;
        #1;
        check("async_ovalid", 32'(out_s.valid), 0);
        check("async_level", 32'(level), 0);
        check("async_iready", 32'(in_s.ready), 0);
        in_s.valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        in_s.valid = 1'b1;
        in_s.data  = 8'hA5;
        step();
        check("post_rst_level", 32'(level), 1);
        check("post_rst_odata", 32'(out_s.data), 32'hA5);
        in_s.valid  = 1'b0;
        out_s.ready = 1'b1;
        step();
        check("post_rst_empty", 32'(out_s.valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
